trap_sequencer: RTL and testbench
=================================

# trap_sequencer

Machine-mode trap and return sequencer for the 3-stage pipeline. It owns the interrupt CSRs (mstatus, mie, mip, mtvec, mepc, mcause) and serves CSR reads and writes issued in the memory/writeback stage. It detects enabled timer and external interrupts and runs a multi-cycle entry sequence: squash, save, redirect to mtvec. It runs the matching mret exit sequence, using the is_mret decode, and drives the pipeline's redirect, flush and stall lines.

## Interface
- XLEN, 32, datapath width
- MTVEC_RST, 32'h0000_0000, reset value of mtvec
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- inst_valid  in  1  stage-2 (MW) slot holds a real instruction
- pc_mw  in  XLEN  PC of the MW-stage instruction
- is_mret  in  1  MW instruction is mret
- csr_rd  in  1  MW instruction reads a CSR
- csr_wr  in  1  MW instruction writes a CSR
- csr_addr  in  12  CSR address (inst[31:20])
- csr_wdata  in  XLEN  CSR write data (rs1 value)
- timer_irq  in  1  level-sensitive timer interrupt
- ext_irq  in  1  level-sensitive external interrupt
- csr_rdata  out  XLEN  combinational read data; 0 when csr_rd=0 or address unmapped
- epc_taken  out  1  PC redirect this cycle
- epc_out  out  XLEN  redirect target, valid when epc_taken=1, else 0
- flush  out  1  kill the IF/ID and MW instructions (no RF or memory write)
- stall  out  1  hold PC and pipeline registers

## Operation
- CSR map (other addresses read 0, writes ignored):
  - mstatus 0x300: only MIE[3] and MPIE[7] implemented.
  - mie 0x304: only MTIE[7] and MEIE[11] implemented.
  - mip 0x344: read-only, MTIP[7]=timer_irq, MEIP[11]=ext_irq.
  - mtvec 0x305: direct mode only; target is {mtvec[31:2],2'b00}.
  - mepc 0x341: bits [1:0] written as 0.
  - mcause 0x342: full word.
- irq_req = MIE & ((MEIE & ext_irq) | (MTIE & timer_irq)).
- Priority: external over timer. Cause is 32'h8000_000B for external, 32'h8000_0007 for timer.
- FSM states are IDLE, SAVE, RESTORE and JUMP.
- IDLE with inst_valid & irq_req:
  - flush=1 combinationally, squashing the MW instruction, including any same-cycle CSR write.
  - At the clock edge: mepc<=pc_mw, mcause<=cause, then go to SAVE.
  - irq_req has priority over is_mret.
- IDLE with inst_valid & is_mret & !irq_req: go to RESTORE. No flush in this cycle.
- IDLE otherwise: csr_wr commits at the clock edge. Go to SAVE/RESTORE only on the conditions above.
- SAVE: stall=1, flush=1. MPIE<=MIE, MIE<=0. Then go to JUMP(tvec).
- RESTORE: stall=1, flush=1. MIE<=MPIE, MPIE<=1. Then go to JUMP(epc).
- JUMP: epc_taken=1, flush=1, stall=0. epc_out={mtvec[31:2],2'b00} or mepc, according to the registered target select. Then go to IDLE.
- CSR writes are ignored outside IDLE.
- Interrupts are not sampled outside IDLE. A level still asserted is taken at the first valid instruction after returning to IDLE.

## Timing
- Trap entry: detect in cycle N, SAVE in N+1, redirect in N+2. The handler's first fetch occurs in N+3.
- mret: RESTORE in N+1, redirect in N+2.
- CSR read latency is 0 (combinational).
- A CSR write is visible the cycle after it commits, including its effect on irq_req.
- Reset values:
  - Registers: mstatus=0, mie=0, mtvec=MTVEC_RST, mepc=0, mcause=0, state=IDLE.
  - Outputs: flush, stall and epc_taken all 0; epc_out=0.
- rst asserted in any state forces IDLE on the next edge and aborts any pending CSR update.
- inst_valid=0 (a bubble) blocks both trap entry and mret.

## Structure
- Package trap_pkg holds:
  - CSR address localparams.
  - Bit-index constants for MIE, MPIE, MTIE and MEIE.
  - Cause constants.
  - State enum (IDLE, SAVE, RESTORE, JUMP).
- Sub-module trap_csr_file holds CSR storage, read mux and write-enable decode. The FSM, priority logic and pipeline controls stay in trap_sequencer.

## Test plan
- CSR write then read:
  - Write mtvec=0x104 in IDLE; next cycle csr_rdata=0x104.
  - Write mepc=0x203; readback = 0x200.
- Timer trap:
  - Setup: MIE=1, MTIE=1, timer_irq=1, pc_mw=0x40.
  - flush in N. SAVE in N+1 with stall=1. N+2: epc_taken=1, epc_out=mtvec.
  - Final state: mepc=0x40, mcause=0x8000_0007, MIE=0, MPIE=1.
- Priority and masking:
  - ext_irq and timer_irq both high gives mcause=0x8000_000B.
  - MIE=0 gives no flush.
- mret:
  - Setup: mepc=0x40, MPIE=1; is_mret with inst_valid.
  - RESTORE, then JUMP with epc_out=0x40. Result: MIE=1, MPIE=1.
- Collisions:
  - irq_req with a same-cycle csr_wr to mie: the write is dropped.
  - irq_req with is_mret: the trap is taken.
  - inst_valid=0: no action.
- Reset asserted during SAVE: next cycle IDLE, all outputs 0, CSRs at reset values.

Source files
------------

// File: rtl/trap_pkg.sv
// ---------------------------------------------------------------------------
// trap_pkg
// Shared definitions for the machine-mode trap sequencer:
//   - CSR addresses of the implemented interrupt CSRs
//   - bit positions of the implemented mstatus / mie / mip fields
//   - mcause values for the two supported interrupt sources
//   - sequencer state and redirect-target enumerations
// ---------------------------------------------------------------------------
package trap_pkg;

   // CSR addresses (inst[31:20])
   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MIP     = 12'h344;

   // Implemented bit positions
   localparam int unsigned MSTATUS_MIE  = 3;
   localparam int unsigned MSTATUS_MPIE = 7;
   localparam int unsigned MIE_MTIE     = 7;   // also MIP_MTIP
   localparam int unsigned MIE_MEIE     = 11;  // also MIP_MEIP

   // Interrupt cause codes (interrupt bit set)
   localparam logic [31:0] CAUSE_M_TIMER = 32'h8000_0007;
   localparam logic [31:0] CAUSE_M_EXT   = 32'h8000_000B;

   // Sequencer states
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SAVE    = 2'd1,
      RESTORE = 2'd2,
      JUMP    = 2'd3
   } state_e;

   // Where the JUMP state redirects the pipeline
   typedef enum logic {
      TGT_TVEC = 1'b0,
      TGT_EPC  = 1'b1
   } target_e;

endpackage

// File: rtl/trap_csr_file.sv
// ---------------------------------------------------------------------------
// trap_csr_file
// Storage, write decode and combinational read mux for the interrupt CSRs
// (mstatus, mie, mip, mtvec, mepc, mcause). Only the architecturally
// implemented bits are stored; everything else reads as zero.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   csr_we_i          commit a software CSR write this cycle (already qualified)
//   csr_rd_i          a CSR read is requested (gates csr_rdata_o)
//   csr_addr_i        CSR address
//   csr_wdata_i       CSR write data
//   trap_save_i       trap entry detected: capture mepc / mcause
//   trap_pc_i         PC to save into mepc
//   trap_cause_i      cause to save into mcause
//   enter_i           SAVE step: MPIE <= MIE, MIE <= 0
//   exit_i            RESTORE step: MIE <= MPIE, MPIE <= 1
//   timer_irq_i       live timer interrupt level (mip.MTIP)
//   ext_irq_i         live external interrupt level (mip.MEIP)
//   csr_rdata_o       read data, 0 when not reading or unmapped
//   mstatus_mie_o     global interrupt enable
//   mie_mtie_o        timer interrupt enable
//   mie_meie_o        external interrupt enable
//   mtvec_o           raw mtvec value
//   mepc_o            mepc value
// ---------------------------------------------------------------------------
module trap_csr_file
   import trap_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            csr_we_i,
   input  logic            csr_rd_i,
   input  logic [11:0]     csr_addr_i,
   input  logic [XLEN-1:0] csr_wdata_i,
   input  logic            trap_save_i,
   input  logic [XLEN-1:0] trap_pc_i,
   input  logic [XLEN-1:0] trap_cause_i,
   input  logic            enter_i,
   input  logic            exit_i,
   input  logic            timer_irq_i,
   input  logic            ext_irq_i,
   output logic [XLEN-1:0] csr_rdata_o,
   output logic            mstatus_mie_o,
   output logic            mie_mtie_o,
   output logic            mie_meie_o,
   output logic [XLEN-1:0] mtvec_o,
   output logic [XLEN-1:0] mepc_o
);

   // mepc is always word aligned, whatever is written into it
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

   logic            mstatus_mie_q, mstatus_mie_d;
   logic            mstatus_mpie_q, mstatus_mpie_d;
   logic            mie_mtie_q, mie_mtie_d;
   logic            mie_meie_q, mie_meie_d;
   logic [XLEN-1:0] mtvec_q, mtvec_d;
   logic [XLEN-1:0] mepc_q, mepc_d;
   logic [XLEN-1:0] mcause_q, mcause_d;

   logic we_mstatus, we_mie, we_mtvec, we_mepc, we_mcause;

   // Per-register write enables; mip is read-only so it has none
   assign we_mstatus = csr_we_i && (csr_addr_i == CSR_MSTATUS);
   assign we_mie     = csr_we_i && (csr_addr_i == CSR_MIE);
   assign we_mtvec   = csr_we_i && (csr_addr_i == CSR_MTVEC);
   assign we_mepc    = csr_we_i && (csr_addr_i == CSR_MEPC);
   assign we_mcause  = csr_we_i && (csr_addr_i == CSR_MCAUSE);

   // Next-state logic. The sequencer never asserts a software write together
   // with enter/exit/save, but the hardware updates win if it ever did.
   // NOTE: every combinational output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      mstatus_mie_d  = mstatus_mie_q;
      mstatus_mpie_d = mstatus_mpie_q;
      mie_mtie_d     = mie_mtie_q;
      mie_meie_d     = mie_meie_q;
      mtvec_d        = mtvec_q;
      mepc_d         = mepc_q;
      mcause_d       = mcause_q;

      if (enter_i) begin
         mstatus_mpie_d = mstatus_mie_q;
         mstatus_mie_d  = 1'b0;
      end else if (exit_i) begin
         mstatus_mie_d  = mstatus_mpie_q;
         mstatus_mpie_d = 1'b1;
      end else if (we_mstatus) begin
         mstatus_mie_d  = csr_wdata_i[MSTATUS_MIE];
         mstatus_mpie_d = csr_wdata_i[MSTATUS_MPIE];
      end

      if (we_mie) begin
         mie_mtie_d = csr_wdata_i[MIE_MTIE];
         mie_meie_d = csr_wdata_i[MIE_MEIE];
      end

      if (we_mtvec) begin
         mtvec_d = csr_wdata_i;
      end

      if (trap_save_i) begin
         mepc_d   = trap_pc_i & ALIGN_MASK;
         mcause_d = trap_cause_i;
      end else begin
         if (we_mepc)   mepc_d   = csr_wdata_i & ALIGN_MASK;
         if (we_mcause) mcause_d = csr_wdata_i;
      end
   end

   // Reset has priority, so an update pending in the reset cycle is dropped.
   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
         mie_mtie_q     <= 1'b0;
         mie_meie_q     <= 1'b0;
         mtvec_q        <= XLEN'(MTVEC_RST);
         mepc_q         <= '0;
         mcause_q       <= '0;
      end else begin
         mstatus_mie_q  <= mstatus_mie_d;
         mstatus_mpie_q <= mstatus_mpie_d;
         mie_mtie_q     <= mie_mtie_d;
         mie_meie_q     <= mie_meie_d;
         mtvec_q        <= mtvec_d;
         mepc_q         <= mepc_d;
         mcause_q       <= mcause_d;
      end
   end

   // Combinational read mux
   always_comb begin
      csr_rdata_o = '0;
      if (csr_rd_i) begin
         case (csr_addr_i)
            CSR_MSTATUS: begin
               csr_rdata_o[MSTATUS_MIE]  = mstatus_mie_q;
               csr_rdata_o[MSTATUS_MPIE] = mstatus_mpie_q;
            end
            CSR_MIE: begin
               csr_rdata_o[MIE_MTIE] = mie_mtie_q;
               csr_rdata_o[MIE_MEIE] = mie_meie_q;
            end
            CSR_MIP: begin
               csr_rdata_o[MIE_MTIE] = timer_irq_i;
               csr_rdata_o[MIE_MEIE] = ext_irq_i;
            end
            CSR_MTVEC:  csr_rdata_o = mtvec_q;
            CSR_MEPC:   csr_rdata_o = mepc_q;
            CSR_MCAUSE: csr_rdata_o = mcause_q;
            default:    csr_rdata_o = '0;
         endcase
      end
   end

   assign mstatus_mie_o = mstatus_mie_q;
   assign mie_mtie_o    = mie_mtie_q;
   assign mie_meie_o    = mie_meie_q;
   assign mtvec_o       = mtvec_q;
   assign mepc_o        = mepc_q;

endmodule

// File: rtl/trap_sequencer.sv
// ---------------------------------------------------------------------------
// trap_sequencer
// Machine-mode trap entry / mret exit sequencer for the 3-stage pipeline.
// Detects enabled timer/external interrupts against the MW-stage
// instruction, squashes it, saves mepc/mcause, updates mstatus and redirects
// to mtvec; runs the mirror sequence for mret back to mepc.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   inst_valid   MW slot holds a real instruction
//   pc_mw        PC of the MW instruction
//   is_mret      MW instruction is mret
//   csr_rd       MW instruction reads a CSR
//   csr_wr       MW instruction writes a CSR
//   csr_addr     CSR address
//   csr_wdata    CSR write data
//   timer_irq    level-sensitive timer interrupt
//   ext_irq      level-sensitive external interrupt
//   csr_rdata    combinational CSR read data
//   epc_taken    PC redirect this cycle
//   epc_out      redirect target (0 when no redirect)
//   flush        kill the IF/ID and MW instructions
//   stall        hold PC and pipeline registers
// ---------------------------------------------------------------------------
module trap_sequencer
   import trap_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            inst_valid,
   input  logic [XLEN-1:0] pc_mw,
   input  logic            is_mret,
   input  logic            csr_rd,
   input  logic            csr_wr,
   input  logic [11:0]     csr_addr,
   input  logic [XLEN-1:0] csr_wdata,
   input  logic            timer_irq,
   input  logic            ext_irq,
   output logic [XLEN-1:0] csr_rdata,
   output logic            epc_taken,
   output logic [XLEN-1:0] epc_out,
   output logic            flush,
   output logic            stall
);

   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

   state_e  state_q, state_d;
   target_e tgt_q, tgt_d;

   logic            mstatus_mie, mie_mtie, mie_meie;
   logic [XLEN-1:0] mtvec, mepc;

   logic            ext_pend, timer_pend, irq_req;
   logic            in_idle, trap_take, mret_take, csr_we;
   logic [XLEN-1:0] trap_cause;

   // Interrupt detection works off registered CSR state only, so a CSR
   // write affects irq_req from the following cycle on.
   assign ext_pend   = mie_meie & ext_irq;
   assign timer_pend = mie_mtie & timer_irq;
   assign irq_req    = mstatus_mie & (ext_pend | timer_pend);

   // External wins over timer when both are pending
   assign trap_cause = ext_pend ? XLEN'(CAUSE_M_EXT) : XLEN'(CAUSE_M_TIMER);

   assign in_idle   = (state_q == IDLE);
   // A trap beats mret; a bubble starts neither sequence
   assign trap_take = in_idle & inst_valid & irq_req;
   assign mret_take = in_idle & inst_valid & is_mret & ~irq_req;
   // The trapped instruction is squashed, so its CSR write must not land
   assign csr_we    = in_idle & csr_wr & ~trap_take;

   trap_csr_file #(
      .XLEN      (XLEN),
      .MTVEC_RST (MTVEC_RST)
   ) u_csr (
      .clk           (clk),
      .rst           (rst),
      .csr_we_i      (csr_we),
      .csr_rd_i      (csr_rd),
      .csr_addr_i    (csr_addr),
      .csr_wdata_i   (csr_wdata),
      .trap_save_i   (trap_take),
      .trap_pc_i     (pc_mw),
      .trap_cause_i  (trap_cause),
      .enter_i       (state_q == SAVE),
      .exit_i        (state_q == RESTORE),
      .timer_irq_i   (timer_irq),
      .ext_irq_i     (ext_irq),
      .csr_rdata_o   (csr_rdata),
      .mstatus_mie_o (mstatus_mie),
      .mie_mtie_o    (mie_mtie),
      .mie_meie_o    (mie_meie),
      .mtvec_o       (mtvec),
      .mepc_o        (mepc)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         tgt_q   <= TGT_TVEC;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
      end
   end

   // Next-state logic; the redirect target is latched on the way into JUMP
   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      case (state_q)
         IDLE: begin
            if (trap_take)      state_d = SAVE;
            else if (mret_take) state_d = RESTORE;
         end
         SAVE: begin
            state_d = JUMP;
            tgt_d   = TGT_TVEC;
         end
         RESTORE: begin
            state_d = JUMP;
            tgt_d   = TGT_EPC;
         end
         JUMP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Pipeline control outputs
   always_comb begin
      flush     = 1'b0;
      stall     = 1'b0;
      epc_taken = 1'b0;
      epc_out   = '0;
      case (state_q)
         IDLE:    flush = trap_take;
         SAVE,
         RESTORE: begin
            flush = 1'b1;
            stall = 1'b1;
         end
         JUMP: begin
            flush     = 1'b1;
            epc_taken = 1'b1;
            epc_out   = (tgt_q == TGT_EPC) ? mepc : (mtvec & ALIGN_MASK);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_trap_sequencer.sv
// ---------------------------------------------------------------------------
// tb_trap_sequencer
// Self-checking bench for trap_sequencer. The driver applies one stimulus
// per cycle, predicts the DUT outputs from a behavioural model of the CSRs
// plus a queue of scheduled pipeline-control steps, and pushes the
// prediction into a scoreboard. The monitor pops and compares on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_trap_sequencer;

   localparam logic [31:0] MTVEC_RST = 32'h0000_0100;

   logic        clk;
   logic        rst;
   logic        inst_valid;
   logic [31:0] pc_mw;
   logic        is_mret;
   logic        csr_rd;
   logic        csr_wr;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic        timer_irq;
   logic        ext_irq;
   logic [31:0] csr_rdata;
   logic        epc_taken;
   logic [31:0] epc_out;
   logic        flush;
   logic        stall;

   trap_sequencer #(
      .XLEN      (32),
      .MTVEC_RST (MTVEC_RST)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .inst_valid (inst_valid),
      .pc_mw      (pc_mw),
      .is_mret    (is_mret),
      .csr_rd     (csr_rd),
      .csr_wr     (csr_wr),
      .csr_addr   (csr_addr),
      .csr_wdata  (csr_wdata),
      .timer_irq  (timer_irq),
      .ext_irq    (ext_irq),
      .csr_rdata  (csr_rdata),
      .epc_taken  (epc_taken),
      .epc_out    (epc_out),
      .flush      (flush),
      .stall      (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- stimulus / expectation types ----------------
   typedef struct packed {
      logic        rst;
      logic        iv;
      logic [31:0] pc;
      logic        mret;
      logic        rd;
      logic        wr;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic        tirq;
      logic        eirq;
   } stim_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        flush;
      logic        stall;
      logic        taken;
      logic [31:0] epc;
   } exp_t;

   // One scheduled cycle of a trap/mret sequence
   typedef struct packed {
      logic stall;
      logic jump;
      logic to_epc;
      logic save;
      logic restore;
   } act_t;

   exp_t exp_q[$];
   act_t pend[$];

   int n_checks = 0;
   int n_errors = 0;

   // ---------------- reference model state ----------------
   logic        m_mie, m_mpie, m_mtie, m_meie;
   logic [31:0] m_mtvec, m_mepc, m_mcause;
   logic        g_tirq, g_eirq;

   logic [11:0] addr_tab [7] = '{12'h300, 12'h304, 12'h344, 12'h305,
                                 12'h341, 12'h342, 12'h7C0};

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mie = 0; m_mpie = 0; m_mtie = 0; m_meie = 0;
      m_mtvec = MTVEC_RST; m_mepc = 0; m_mcause = 0;
      pend.delete();
   endtask

   function automatic logic [31:0] model_read(input logic [11:0] a,
                                              input logic t, input logic e);
      case (a)
         12'h300: return (32'(m_mie) << 3) | (32'(m_mpie) << 7);
         12'h304: return (32'(m_mtie) << 7) | (32'(m_meie) << 11);
         12'h344: return (32'(t) << 7) | (32'(e) << 11);
         12'h305: return m_mtvec;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_write(input logic [11:0] a, input logic [31:0] d);
      case (a)
         12'h300: begin m_mie = d[3]; m_mpie = d[7]; end
         12'h304: begin m_mtie = d[7]; m_meie = d[11]; end
         12'h305: m_mtvec = d;
         12'h341: m_mepc = d & 32'hFFFF_FFFC;
         12'h342: m_mcause = d;
         default: ;
      endcase
   endtask

   function automatic stim_t nop();
      stim_t s;
      s = '0;
      s.tirq = g_tirq;
      s.eirq = g_eirq;
      return s;
   endfunction

   // Apply one cycle of stimulus, predict outputs, then advance the model
   task automatic drive(input stim_t s);
      exp_t e;
      act_t a;
      logic ext_p, tim_p, irq, take;
      @(posedge clk);
      #1;
      rst = s.rst; inst_valid = s.iv; pc_mw = s.pc; is_mret = s.mret;
      csr_rd = s.rd; csr_wr = s.wr; csr_addr = s.addr; csr_wdata = s.wdata;
      timer_irq = s.tirq; ext_irq = s.eirq;

      e = '0;
      e.rdata = s.rd ? model_read(s.addr, s.tirq, s.eirq) : 32'h0;
      ext_p = m_meie & s.eirq;
      tim_p = m_mtie & s.tirq;
      irq   = m_mie & (ext_p | tim_p);
      take  = 1'b0;
      if (pend.size() > 0) begin
         a = pend[0];
         e.flush = 1'b1;
         e.stall = a.stall;
         e.taken = a.jump;
         if (a.jump) e.epc = a.to_epc ? m_mepc : (m_mtvec & 32'hFFFF_FFFC);
      end else begin
         take    = s.iv & irq;
         e.flush = take;
      end
      exp_q.push_back(e);

      if (s.rst) begin
         model_reset();
      end else if (pend.size() > 0) begin
         a = pend.pop_front();
         if (a.save)    begin m_mpie = m_mie; m_mie = 1'b0; end
         if (a.restore) begin m_mie = m_mpie; m_mpie = 1'b1; end
      end else if (take) begin
         m_mepc   = s.pc & 32'hFFFF_FFFC;
         m_mcause = ext_p ? 32'h8000_000B : 32'h8000_0007;
         pend.push_back('{stall: 1, jump: 0, to_epc: 0, save: 1, restore: 0});
         pend.push_back('{stall: 0, jump: 1, to_epc: 0, save: 0, restore: 0});
      end else begin
         if (s.iv && s.mret) begin
            pend.push_back('{stall: 1, jump: 0, to_epc: 0, save: 0, restore: 1});
            pend.push_back('{stall: 0, jump: 1, to_epc: 1, save: 0, restore: 0});
         end
         if (s.wr) model_write(s.addr, s.wdata);
      end
   endtask

   task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
      stim_t s;
      s = nop(); s.iv = 1; s.wr = 1; s.addr = a; s.wdata = d;
      drive(s);
   endtask

   task automatic csr_read(input logic [11:0] a);
      stim_t s;
      s = nop(); s.rd = 1; s.addr = a;
      drive(s);
   endtask

   task automatic exec(input logic [31:0] pc, input logic mret);
      stim_t s;
      s = nop(); s.iv = 1; s.pc = pc; s.mret = mret;
      drive(s);
   endtask

   // ---------------- monitor ----------------
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("csr_rdata", csr_rdata, e.rdata);
            check("flush", 32'(flush), 32'(e.flush));
            check("stall", 32'(stall), 32'(e.stall));
            check("epc_taken", 32'(epc_taken), 32'(e.taken));
            check("epc_out", epc_out, e.epc);
         end
      end
   end

   // ---------------- main stimulus ----------------
   initial begin
      stim_t s;
      g_tirq = 0; g_eirq = 0;
      rst = 1; inst_valid = 0; pc_mw = 0; is_mret = 0; csr_rd = 0;
      csr_wr = 0; csr_addr = 0; csr_wdata = 0; timer_irq = 0; ext_irq = 0;
      model_reset();
      repeat (3) @(posedge clk);

      // Reset values of every CSR plus an unmapped address
      for (int i = 0; i < 7; i++) csr_read(addr_tab[i]);

      // Write then read back
      csr_write(12'h305, 32'h0000_0104); csr_read(12'h305);
      csr_write(12'h341, 32'h0000_0203); csr_read(12'h341);
      csr_write(12'h342, 32'hDEAD_BEEF); csr_read(12'h342);
      csr_write(12'h300, 32'hFFFF_FFFF); csr_read(12'h300);
      csr_write(12'h304, 32'hFFFF_FFFF); csr_read(12'h304);
      csr_write(12'h344, 32'hFFFF_FFFF); csr_read(12'h344);
      csr_write(12'h7C0, 32'h1234_5678); csr_read(12'h7C0);

      // Timer trap at pc 0x40
      csr_write(12'h300, 32'h0000_0008);
      csr_write(12'h304, 32'h0000_0080);
      g_tirq = 1;
      exec(32'h40, 0);                    // detect, flush
      exec(32'h44, 0);                    // SAVE
      exec(32'h48, 0);                    // JUMP to mtvec
      g_tirq = 0;
      csr_read(12'h341); csr_read(12'h342); csr_read(12'h300);

      // mret back to 0x40
      exec(32'h1F0, 1);                   // detect
      exec(32'h1F4, 0);                   // RESTORE
      exec(32'h1F8, 0);                   // JUMP to mepc
      csr_read(12'h300);

      // Both sources high: external wins
      csr_write(12'h304, 32'h0000_0880);
      g_tirq = 1; g_eirq = 1;
      exec(32'h80, 0); exec(32'h84, 0); exec(32'h88, 0);
      csr_read(12'h342); csr_read(12'h341);

      // MIE=0 after entry: no trap even with both levels high
      exec(32'h104, 0); exec(32'h108, 0);

      // Trap beats mret in the same cycle
      csr_write(12'h300, 32'h0000_0008);
      exec(32'hC0, 1); exec(32'hC4, 0); exec(32'hC8, 0);
      csr_read(12'h342); csr_read(12'h341); csr_read(12'h300);

      // Same-cycle mie write under a trap is dropped
      csr_write(12'h300, 32'h0000_0008);
      csr_write(12'h304, 32'h0000_0000);  // trap taken here, write lost
      exec(32'h10, 0); exec(32'h14, 0);
      csr_read(12'h304);

      // A bubble blocks entry and mret
      csr_write(12'h300, 32'h0000_0008);
      s = nop(); s.pc = 32'h200; drive(s);
      s = nop(); s.pc = 32'h204; s.mret = 1; drive(s);
      csr_read(12'h300);

      // Reset during SAVE
      exec(32'h300, 0);
      s = nop(); s.rst = 1; drive(s);     // SAVE cycle with reset asserted
      g_tirq = 0; g_eirq = 0;
      s = nop(); drive(s);
      for (int i = 0; i < 7; i++) csr_read(addr_tab[i]);

      // Randomised traffic
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(9) == 0) g_tirq = ~g_tirq;
         if ($urandom_range(9) == 0) g_eirq = ~g_eirq;
         s = nop();
         s.iv    = ($urandom_range(9) < 8);
         s.pc    = $urandom & 32'hFFFF_FFFC;
         s.mret  = ($urandom_range(19) == 0);
         s.rd    = ($urandom_range(9) < 6);
         s.wr    = ($urandom_range(9) < 2);
         s.addr  = addr_tab[$urandom_range(6)];
         s.wdata = $urandom;
         drive(s);
      end

      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
